fetch_stage: RTL and testbench

Instruction-fetch stage with the IF/ID pipeline register. Owns the PC, issues instruction-memory requests (one outstanding) and delivers {pc, instr} to decode. Honours the hazard unit's Stall (hold PC and IF/ID) and Flush (redirect to the EX branch/jump target, squash younger work). Sits directly upstream of decode and the hazard unit.

---
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, keeps one imem request in flight,
// and holds the IF/ID register handed to decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_pc;
  logic [31:0] buf_instr;
  logic        accept;
  logic        grant;
  logic        resp;

  assign accept      = !stall && !flush;
  assign resp        = (state == WAIT) && imem_rvalid && !flush;
  assign grant       = imem_req && imem_gnt;
  assign imem_addr   = pc;
  assign id_pc_plus4 = id_pc + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      FETCH: if (grant) state_nx = WAIT;
      WAIT: begin
        if (flush)
          state_nx = imem_rvalid ? FETCH : DROP;
        else if (imem_rvalid)
          state_nx = grant ? WAIT : FETCH;
      end
      DROP:    if (imem_rvalid) state_nx = FETCH;
      default: state_nx = FETCH;
    endcase
  end

  // Re-request in WAIT only when the response is consumed this cycle.
  always_comb begin
    imem_req = 1'b0;
    if (rst_n && !flush && !buf_valid) begin
      unique case (state)
        FETCH:   imem_req = 1'b1;
        WAIT:    imem_req = imem_rvalid && accept;
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      if (flush)      pc <= redirect_pc;
      else if (grant) pc <= pc + 32'd4;
      if (grant) req_pc <= pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_pc    <= 32'd0;
      buf_instr <= 32'd0;
    end else if (flush) begin
      buf_valid <= 1'b0;
    end else if (resp && stall) begin
      buf_valid <= 1'b1;
      buf_pc    <= req_pc;
      buf_instr <= imem_rdata;
    end else if (accept) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_instr <= NOP_INSTR;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_pc    <= 32'd0;
      id_instr <= NOP_INSTR;
    end else if (accept) begin
      unique case (1'b1)
        buf_valid: begin
          id_valid <= 1'b1;
          id_pc    <= buf_pc;
          id_instr <= buf_instr;
        end
        resp: begin
          id_valid <= 1'b1;
          id_pc    <= req_pc;
          id_instr <= imem_rdata;
        end
        default: begin
          id_valid <= 1'b0;
          id_pc    <= 32'd0;
          id_instr <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: program-order stream model plus
// directed literal checks on latency, stall, flush, wrap, reset.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .stall(stall), .flush(flush),
    .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4),
    .id_instr(id_instr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cyc %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Memory responder plus one clock; returns on the next negedge.
  task automatic tick();
    if (q.size() > 0 && q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_of(q[0].addr);
      q.delete(0);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    #1;
    if (imem_req && imem_gnt)
      q.push_back('{cyc + lat, imem_addr});
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Reference model: fetch pointer and next in-order delivery PC.
  logic [31:0] fpc;
  logic [31:0] exp_pc;
  logic        p_req, p_gnt, p_stall, p_flush, p_v;
  logic [31:0] p_addr, p_red, p_pc, p_in;

  initial begin : compare
    fpc    = 32'd0;
    exp_pc = 32'd0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        fpc    = 32'd0;
        exp_pc = 32'd0;
        #1;
        chk("rst id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst id_instr", id_instr, NOP);
        chk("rst id_pc", id_pc, 32'd0);
        chk("rst imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst imem_addr", imem_addr, 32'd0);
      end else begin
        p_req = imem_req;  p_gnt = imem_gnt;
        p_addr = imem_addr;
        p_stall = stall;   p_flush = flush;
        p_red = redirect_pc;
        p_v = id_valid; p_pc = id_pc; p_in = id_instr;
        #1;
        if (p_req) chk("m req addr", p_addr, fpc);
        if (p_flush) begin
          chk("m flush req", {31'd0, p_req}, 32'd0);
          fpc    = p_red;
          exp_pc = p_red;
          chk("m flush valid", {31'd0, id_valid}, 32'd0);
          chk("m flush instr", id_instr, NOP);
        end else begin
          if (p_req && p_gnt) fpc = fpc + 32'd4;
          if (p_stall) begin
            chk("m stall valid", {31'd0, id_valid},
                {31'd0, p_v});
            chk("m stall pc", id_pc, p_pc);
            chk("m stall instr", id_instr, p_in);
          end else if (id_valid) begin
            chk("m id_pc", id_pc, exp_pc);
            chk("m id_instr", id_instr, mem_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
          end else begin
            chk("m bubble pc", id_pc, 32'd0);
            chk("m bubble instr", id_instr, NOP);
          end
        end
        chk("m plus4", id_pc_plus4, id_pc + 32'd4);
      end
    end
  end

  initial begin : drive
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_pc = 32'd0; imem_gnt = 1'b1;
    imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    tick(); tick();
    chk("reset plus4", id_pc_plus4, 32'd4);
    chk("reset instr", id_instr, NOP);
    chk("reset req", {31'd0, imem_req}, 32'd0);
    chk("reset addr", imem_addr, 32'd0);

    // Back-to-back stream, 1-cycle memory
    rst_n = 1'b1;
    tick();
    chk("lat bubble", {31'd0, id_valid}, 32'd0);
    tick(); chk("seq pc0", id_pc, 32'd0);
    chk("seq instr0", id_instr, 32'hC0DE_0000);
    tick(); chk("seq pc4", id_pc, 32'd4);
    tick(); chk("seq pc8", id_pc, 32'd8);
    tick(); chk("seq pc12", id_pc, 32'd12);

    // Stall across a pending response
    stall = 1'b1;
    tick(); chk("stall req", {31'd0, imem_req}, 32'd0);
    tick(); tick();
    chk("stall frozen", id_pc, 32'd12);
    stall = 1'b0;
    tick(); chk("unstall buf", id_pc, 32'd16);
    tick(); chk("unstall gap", {31'd0, id_valid}, 32'd0);
    tick(); chk("unstall next", id_pc, 32'd20);

    // Flush while WAIT, late response dropped
    lat = 3;
    tick(); chk("pre flush", id_pc, 32'd24);
    flush = 1'b1; redirect_pc = 32'h100;
    tick(); flush = 1'b0;
    chk("flush bubble", {31'd0, id_valid}, 32'd0);
    chk("flush nop", id_instr, NOP);
    tick();
    tick(); chk("drop ignored", {31'd0, id_valid}, 32'd0);
    tick(); lat = 1;
    tick(); tick();
    tick(); chk("redir pc", id_pc, 32'h100);
    tick(); chk("redir next", id_pc, 32'h104);

    // Flush beats stall and clears a full buffer
    stall = 1'b1;
    tick();
    flush = 1'b1; redirect_pc = 32'h200;
    tick();
    chk("fs valid", {31'd0, id_valid}, 32'd0);
    chk("fs instr", id_instr, NOP);
    chk("fs pc", imem_addr, 32'h200);
    flush = 1'b0; stall = 1'b0;
    tick(); chk("fs buf gone", {31'd0, id_valid}, 32'd0);
    tick(); chk("fs deliver", id_pc, 32'h200);

    // Grant withheld
    imem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("nognt addr", imem_addr, 32'h208);
      chk("nognt req", {31'd0, imem_req}, 32'd1);
      if (i > 0)
        chk("nognt bubble", {31'd0, id_valid}, 32'd0);
    end

    // Wrap through 0xFFFF_FFFC
    imem_gnt = 1'b1;
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); flush = 1'b0;
    chk("wrap addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    tick(); chk("wrap pc", id_pc, 32'hFFFF_FFFC);
    chk("wrap plus4", id_pc_plus4, 32'd0);
    chk("wrap next addr", imem_addr, 32'd4);
    tick(); chk("wrap zero", id_pc, 32'd0);

    // Reset while WAIT, stale response afterwards
    lat = 3;
    tick();
    rst_n = 1'b0;
    #1;
    chk("async valid", {31'd0, id_valid}, 32'd0);
    chk("async req", {31'd0, imem_req}, 32'd0);
    chk("async addr", imem_addr, 32'd0);
    tick();
    rst_n = 1'b1; imem_gnt = 1'b0;
    tick(); tick();
    chk("stale ignored", {31'd0, id_valid}, 32'd0);
    imem_gnt = 1'b1; lat = 1;
    chk("post rst addr", imem_addr, 32'd0);
    tick();
    tick(); chk("post rst pc", id_pc, 32'd0);
    chk("post rst instr", id_instr, 32'hC0DE_0000);
    tick(); tick(); tick();
    chk("post rst seq", id_pc, 32'd12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
